shift_deserializer: RTL and testbench

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

---
 rtl/shift_deserializer.sv | 138 +++++++++++++
 tb/tb_shift_deserializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit frames from a qualified
// serial stream and holds each complete frame until the consumer acknowledges it.
module shift_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     shift_en,
    input  logic                     serial_in,
    input  logic                     data_ack,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic [$clog2(WIDTH):0]   bit_count
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            r_overrun;
    logic            w_overrun_nxt;
    logic            r_valid;
    logic            r_busy;

    // LSB-first frames fill from the top so the first bit ends up in bit 0.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word, input logic b);
        logic [WIDTH-1:0] res;
        if (LSB_FIRST) begin
            res = {b, word[WIDTH-1:1]};
        end else begin
            res = {word[WIDTH-2:0], b};
        end
        return res;
    endfunction

    // Next-state, shift register, bit counter and overrun flag.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_count_nxt   = r_count;
        w_overrun_nxt = r_overrun;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_SHIFT;
                    w_shift_nxt   = '0;
                    w_count_nxt   = '0;
                    w_overrun_nxt = 1'b0;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    // Abort: restart the frame, any concurrent bit is dropped.
                    w_shift_nxt   = '0;
                    w_count_nxt   = '0;
                    w_overrun_nxt = 1'b0;
                end else if (shift_en) begin
                    w_shift_nxt = shift_in(r_shift, serial_in);
                    w_count_nxt = r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) begin
                        w_state_nxt = ST_FULL;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_FULL: begin
                if (start && data_ack) begin
                    w_state_nxt   = ST_SHIFT;
                    w_shift_nxt   = '0;
                    w_count_nxt   = '0;
                    w_overrun_nxt = 1'b0;
                end else begin
                    if (data_ack) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                    if (shift_en) begin
                        w_overrun_nxt = 1'b1;
                    end else begin
                        w_overrun_nxt = r_overrun;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_shift_nxt   = '0;
                w_count_nxt   = '0;
                w_overrun_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; flags are derived from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_count   <= w_count_nxt;
            r_overrun <= w_overrun_nxt;
            r_valid   <= (w_state_nxt == ST_FULL);
            r_busy    <= (w_state_nxt == ST_SHIFT);
        end
    end

    assign data_out   = r_shift;
    assign data_valid = r_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign bit_count  = r_count;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are
// compared against a bit-queue model of the frame protocol.
module tb_shift_deserializer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic shift_en = 1'b0;
    logic serial_in = 1'b0;
    logic data_ack = 1'b0;

    logic [7:0] dl_data, dm_data;
    logic       dl_valid, dm_valid, dl_busy, dm_busy, dl_ovr, dm_ovr;
    logic [3:0] dl_cnt, dm_cnt;

    int errors = 0;
    int checks = 0;

    // Model: 0 idle, 1 receiving, 2 frame held
    int m_st = 0;
    bit m_bits[$];
    bit m_ovr = 1'b0;

    logic [7:0] seq = 8'h4D;  // bit k = k-th bit sent: 1,0,1,1,0,0,1,0

    always #5 clock = ~clock;

    shift_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
        .clock(clock), .reset(reset), .start(start), .shift_en(shift_en),
        .serial_in(serial_in), .data_ack(data_ack), .data_out(dl_data),
        .data_valid(dl_valid), .busy(dl_busy), .overrun(dl_ovr), .bit_count(dl_cnt));

    shift_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clock(clock), .reset(reset), .start(start), .shift_en(shift_en),
        .serial_in(serial_in), .data_ack(data_ack), .data_out(dm_data),
        .data_valid(dm_valid), .busy(dm_busy), .overrun(dm_ovr), .bit_count(dm_cnt));

    function automatic logic [7:0] exp_word(input bit lsb);
        logic [7:0] w;
        int n;
        w = 8'h00;
        n = m_bits.size();
        for (int k = 0; k < n; k++) begin
            if (lsb) w[8 - n + k] = m_bits[k];
            else     w[n - 1 - k] = m_bits[k];
        end
        return w;
    endfunction

    function automatic logic [3:0] exp_status;
        return {(m_st == 2) ? 1'b1 : 1'b0, (m_st == 1) ? 1'b1 : 1'b0, m_ovr, 1'b0};
    endfunction

    task automatic cycle(input logic st, input logic se, input logic si,
                         input logic ack, input logic rs);
        @(negedge clock);
        start = st; shift_en = se; serial_in = si; data_ack = ack; reset = rs;
        @(posedge clock);
        if (rs) begin
            m_st = 0; m_bits.delete(); m_ovr = 1'b0;
        end else if (m_st == 0) begin
            if (st) begin m_st = 1; m_bits.delete(); m_ovr = 1'b0; end
        end else if (m_st == 1) begin
            if (st) begin
                m_bits.delete(); m_ovr = 1'b0;
            end else if (se) begin
                m_bits.push_back(si);
                if (m_bits.size() == 8) m_st = 2;
            end
        end else begin
            if (st && ack) begin
                m_st = 1; m_bits.delete(); m_ovr = 1'b0;
            end else begin
                if (se) m_ovr = 1'b1;
                if (ack) m_st = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({dl_data, dl_valid, dl_busy, dl_ovr, dl_cnt} !== 15'd0) begin
            errors++; $display("FAIL reset_lsb: got %h want 0", {dl_data, dl_valid, dl_busy, dl_ovr, dl_cnt});
        end
        checks++;
        if ({dm_data, dm_valid, dm_busy, dm_ovr, dm_cnt} !== 15'd0) begin
            errors++; $display("FAIL reset_msb: got %h want 0", {dm_data, dm_valid, dm_busy, dm_ovr, dm_cnt});
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_frame;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                checks++;
                if (dl_valid !== 1'b0) begin errors++; $display("FAIL frame_early_valid: got %b want 0", dl_valid); end
            end
            cycle(1'b0, 1'b1, seq[k], 1'b0, 1'b0);
        end
        checks++;
        if (dl_valid !== 1'b1 || dl_busy !== 1'b0) begin
            errors++; $display("FAIL frame_valid: got valid=%b busy=%b want 1 0", dl_valid, dl_busy);
        end
        checks++;
        if (dl_data !== 8'h4D) begin errors++; $display("FAIL frame_lsb_data: got %h want 4d", dl_data); end
        checks++;
        if (dm_data !== 8'hB2) begin errors++; $display("FAIL frame_msb_data: got %h want b2", dm_data); end
        checks++;
        if (dl_cnt !== 4'd8) begin errors++; $display("FAIL frame_count: got %0d want 8", dl_cnt); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dl_valid !== 1'b0 || dl_busy !== 1'b0) begin
            errors++; $display("FAIL frame_ack: got valid=%b busy=%b want 0 0", dl_valid, dl_busy);
        end
    endtask

    task automatic test_gap;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, seq[k], 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (dl_cnt !== 4'd4 || dl_valid !== 1'b0 || dl_busy !== 1'b1) begin
                errors++; $display("FAIL gap_hold: got cnt=%0d valid=%b busy=%b want 4 0 1", dl_cnt, dl_valid, dl_busy);
            end
        end
        for (int k = 4; k < 8; k++) begin
            checks++;
            if (dl_valid !== 1'b0) begin errors++; $display("FAIL gap_early_valid: got %b want 0", dl_valid); end
            cycle(1'b0, 1'b1, seq[k], 1'b0, 1'b0);
        end
        checks++;
        if (dl_valid !== 1'b1 || dl_data !== 8'h4D) begin
            errors++; $display("FAIL gap_frame: got valid=%b data=%h want 1 4d", dl_valid, dl_data);
        end
    endtask

    task automatic test_overrun;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dl_ovr !== 1'b1 || dl_data !== 8'h4D || dl_valid !== 1'b1 || dl_cnt !== 4'd8) begin
            errors++; $display("FAIL ovr_set: got ovr=%b data=%h valid=%b cnt=%0d want 1 4d 1 8", dl_ovr, dl_data, dl_valid, dl_cnt);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dl_valid !== 1'b1 || dl_data !== 8'h4D || dl_ovr !== 1'b1) begin
            errors++; $display("FAIL full_start_ignored: got valid=%b data=%h ovr=%b want 1 4d 1", dl_valid, dl_data, dl_ovr);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dl_ovr !== 1'b1 || dl_valid !== 1'b0 || dl_busy !== 1'b0) begin
            errors++; $display("FAIL ovr_sticky: got ovr=%b valid=%b busy=%b want 1 0 0", dl_ovr, dl_valid, dl_busy);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dl_ovr !== 1'b1 || dl_cnt !== 4'd8 || dl_busy !== 1'b0) begin
            errors++; $display("FAIL idle_shift_ignored: got ovr=%b cnt=%0d busy=%b want 1 8 0", dl_ovr, dl_cnt, dl_busy);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dl_ovr !== 1'b0 || dl_busy !== 1'b1 || dl_cnt !== 4'd0) begin
            errors++; $display("FAIL ovr_clear: got ovr=%b busy=%b cnt=%0d want 0 1 0", dl_ovr, dl_busy, dl_cnt);
        end
    endtask

    task automatic test_abort;
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dl_cnt !== 4'd0 || dl_data !== 8'h00 || dl_busy !== 1'b1) begin
            errors++; $display("FAIL abort: got cnt=%0d data=%h busy=%b want 0 00 1", dl_cnt, dl_data, dl_busy);
        end
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dl_data !== 8'hFF || dm_data !== 8'hFF || dl_valid !== 1'b1) begin
            errors++; $display("FAIL abort_ones: got %h %h valid=%b want ff ff 1", dl_data, dm_data, dl_valid);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dl_busy !== 1'b1 || dl_valid !== 1'b0 || dl_cnt !== 4'd0 || dl_data !== 8'h00) begin
            errors++; $display("FAIL back_to_back: got busy=%b valid=%b cnt=%0d data=%h want 1 0 0 00", dl_busy, dl_valid, dl_cnt, dl_data);
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, seq[k], 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({dl_data, dl_valid, dl_busy, dl_ovr, dl_cnt} !== 15'd0) begin
            errors++; $display("FAIL reset_mid: got %h want 0", {dl_data, dl_valid, dl_busy, dl_ovr, dl_cnt});
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dl_cnt !== 4'd0 || dl_busy !== 1'b0 || dl_ovr !== 1'b0 || dl_data !== 8'h00) begin
            errors++; $display("FAIL no_start_shift: got cnt=%0d busy=%b ovr=%b data=%h want 0 0 0 00", dl_cnt, dl_busy, dl_ovr, dl_data);
        end
    endtask

    task automatic test_random;
        logic [3:0] st;
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom_range(0, 9) == 0), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
            st = exp_status();
            checks++;
            if (dl_data !== exp_word(1'b1) || dl_cnt !== 4'(m_bits.size())) begin
                errors++; $display("FAIL rand_lsb_data c=%0d: got %h/%0d want %h/%0d", c, dl_data, dl_cnt, exp_word(1'b1), m_bits.size());
            end
            checks++;
            if (dm_data !== exp_word(1'b0) || dm_cnt !== 4'(m_bits.size())) begin
                errors++; $display("FAIL rand_msb_data c=%0d: got %h/%0d want %h/%0d", c, dm_data, dm_cnt, exp_word(1'b0), m_bits.size());
            end
            checks++;
            if ({dl_valid, dl_busy, dl_ovr} !== st[3:1]) begin
                errors++; $display("FAIL rand_lsb_flags c=%0d: got %b want %b", c, {dl_valid, dl_busy, dl_ovr}, st[3:1]);
            end
            checks++;
            if ({dm_valid, dm_busy, dm_ovr} !== st[3:1]) begin
                errors++; $display("FAIL rand_msb_flags c=%0d: got %b want %b", c, {dm_valid, dm_busy, dm_ovr}, st[3:1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_gap();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
